// File: rtl/char_tbl_pkg.sv
// Shared glyph code map, FSM state encoding and default geometry for the character text path.
// Imported by the frame store and the display stage so the code map lives in one place.
package char_tbl_pkg;

    localparam int DEF_COLS = 40;
    localparam int DEF_ROWS = 15;

    localparam logic [5:0] CH_A = 6'd0;
    localparam logic [5:0] CH_B = 6'd1;
    localparam logic [5:0] CH_C = 6'd2;
    localparam logic [5:0] CH_D = 6'd3;
    localparam logic [5:0] CH_E = 6'd4;
    localparam logic [5:0] CH_F = 6'd5;
    localparam logic [5:0] CH_G = 6'd6;
    localparam logic [5:0] CH_H = 6'd7;
    localparam logic [5:0] CH_I = 6'd8;
    localparam logic [5:0] CH_J = 6'd9;
    localparam logic [5:0] CH_K = 6'd10;
    localparam logic [5:0] CH_L = 6'd11;
    localparam logic [5:0] CH_M = 6'd12;
    localparam logic [5:0] CH_N = 6'd13;
    localparam logic [5:0] CH_O = 6'd14;
    localparam logic [5:0] CH_P = 6'd15;
    localparam logic [5:0] CH_Q = 6'd16;
    localparam logic [5:0] CH_R = 6'd17;
    localparam logic [5:0] CH_S = 6'd18;
    localparam logic [5:0] CH_T = 6'd19;
    localparam logic [5:0] CH_U = 6'd20;
    localparam logic [5:0] CH_V = 6'd21;
    localparam logic [5:0] CH_W = 6'd22;
    localparam logic [5:0] CH_X = 6'd23;
    localparam logic [5:0] CH_Y = 6'd24;
    localparam logic [5:0] CH_Z = 6'd25;
    localparam logic [5:0] CH_1 = 6'd26;
    localparam logic [5:0] CH_2 = 6'd27;
    localparam logic [5:0] CH_3 = 6'd28;
    localparam logic [5:0] CH_4 = 6'd29;
    localparam logic [5:0] CH_5 = 6'd30;
    localparam logic [5:0] CH_6 = 6'd31;
    localparam logic [5:0] CH_7 = 6'd32;
    localparam logic [5:0] CH_8 = 6'd33;
    localparam logic [5:0] CH_9 = 6'd34;
    localparam logic [5:0] CH_0 = 6'd35;
    localparam logic [5:0] CH_SPACE   = 6'd36;
    localparam logic [5:0] CH_NEWLINE = 6'd62;
    localparam logic [5:0] CH_CLEAR   = 6'd63;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_RUN    = 2'd1,
        ST_SCROLL = 2'd2
    } buf_state_e;

    function automatic logic is_printable(input logic [5:0] code);
        return code <= CH_SPACE;
    endfunction

endpackage

// File: rtl/char_cell_ram.sv
// Cell storage: one write port and two registered read ports, read-before-write on every port.
module char_cell_ram #(
    parameter int DEPTH = 600,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [5:0]    wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [5:0]    rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [5:0]    rdata_b
);

    logic [5:0] mem [DEPTH];
    logic [5:0] rdata_a_q;
    logic [5:0] rdata_b_q;

    // Reads sample the array before this edge's write lands, so same-cell collisions return old data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_a_q <= mem[raddr_a];
        rdata_b_q <= mem[raddr_b];
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;

endmodule

// File: rtl/char_text_buffer.sv
// Character-cell frame store with hardware cursor, newline, clear and scroll-up.
// Optional cursor blink is enabled by defining CHAR_TEXT_BUFFER_CURSOR_BLINK_EN.
module char_text_buffer
    import char_tbl_pkg::*;
#(
    parameter int COLS      = DEF_COLS,
    parameter int ROWS      = DEF_ROWS,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] in_code,
    input  logic [5:0] rd_col,
    input  logic [3:0] rd_row,
    output logic [5:0] rd_code,
    output logic [5:0] cur_col,
    output logic [3:0] cur_row,
    output logic       busy,
    output logic       cursor_vis
);

    localparam int CELLS = ROWS * COLS;
    localparam int BODY  = (ROWS - 1) * COLS;
    localparam int AW    = $clog2(CELLS + 1);

    buf_state_e    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [5:0]    col_q, col_d;
    logic [3:0]    row_q, row_d;
    logic          oor_q, oor_d;

    logic          transfer;
    logic          we;
    logic [AW-1:0] waddr;
    logic [5:0]    wdata;
    logic [AW-1:0] cur_addr;
    logic [AW-1:0] disp_addr;
    logic [AW-1:0] scroll_raddr;
    logic [5:0]    disp_data;
    logic [5:0]    scroll_data;

    assign in_ready = (state_q == ST_RUN);
    assign busy     = !in_ready;
    assign transfer = in_valid && in_ready;
    assign cur_addr = AW'(int'(row_q) * COLS + int'(col_q));
    assign cur_col  = col_q;
    assign cur_row  = row_q;

    // Sweep counter idx_q is shared: cell index in CLEAR, scroll step (0..CELLS) in SCROLL.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        col_d        = col_q;
        row_d        = row_q;
        we           = 1'b0;
        waddr        = '0;
        wdata        = CH_SPACE;
        scroll_raddr = '0;
        unique case (state_q)
            ST_CLEAR: begin
                we    = 1'b1;
                waddr = idx_q;
                col_d = '0;
                row_d = '0;
                if (idx_q == AW'(CELLS - 1)) begin
                    idx_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (transfer) begin
                    if (in_code == CH_CLEAR) begin
                        col_d   = '0;
                        row_d   = '0;
                        idx_d   = '0;
                        state_d = ST_CLEAR;
                    end else if (is_printable(in_code) || in_code == CH_NEWLINE) begin
                        if (is_printable(in_code)) begin
                            we    = 1'b1;
                            waddr = cur_addr;
                            wdata = in_code;
                        end
                        if (is_printable(in_code) && int'(col_q) < COLS - 1) begin
                            col_d = col_q + 1'b1;
                        end else begin
                            col_d = '0;
                            if (int'(row_q) < ROWS - 1) begin
                                row_d = row_q + 1'b1;
                            end else begin
                                idx_d   = '0;
                                state_d = ST_SCROLL;
                            end
                        end
                    end
                end
            end
            ST_SCROLL: begin
                // Source cell is fetched one step ahead; its registered data is written the next cycle.
                if (int'(idx_q) + COLS < CELLS) begin
                    scroll_raddr = AW'(int'(idx_q) + COLS);
                end
                if (idx_q != '0) begin
                    we    = 1'b1;
                    waddr = idx_q - 1'b1;
                    wdata = (int'(idx_q) <= BODY) ? scroll_data : CH_SPACE;
                end
                if (idx_q == AW'(CELLS)) begin
                    idx_d   = '0;
                    col_d   = '0;
                    row_d   = 4'(ROWS - 1);
                    state_d = ST_RUN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        oor_d     = (int'(rd_col) >= COLS) || (int'(rd_row) >= ROWS);
        disp_addr = '0;
        if (!oor_d) begin
            disp_addr = AW'(int'(rd_row) * COLS + int'(rd_col));
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            oor_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            col_q   <= col_d;
            row_q   <= row_d;
            oor_q   <= oor_d;
        end
    end

    // oor_q resets high so rd_code shows a blank before the first display read.
    assign rd_code = oor_q ? CH_SPACE : disp_data;

    char_cell_ram #(
        .DEPTH (CELLS),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (disp_addr),
        .rdata_a (disp_data),
        .raddr_b (scroll_raddr),
        .rdata_b (scroll_data)
    );

`ifdef CHAR_TEXT_BUFFER_CURSOR_BLINK_EN
    localparam logic [23:0] BLINK_LAST = 24'(BLINK_DIV - 1);

    logic [23:0] blink_cnt_q, blink_cnt_d;
    logic        cursor_vis_q, cursor_vis_d;

    always_comb begin
        blink_cnt_d  = blink_cnt_q + 1'b1;
        cursor_vis_d = cursor_vis_q;
        if (transfer) begin
            blink_cnt_d  = '0;
            cursor_vis_d = 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d  = '0;
            cursor_vis_d = !cursor_vis_q;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            blink_cnt_q  <= '0;
            cursor_vis_q <= 1'b1;
        end else begin
            blink_cnt_q  <= blink_cnt_d;
            cursor_vis_q <= cursor_vis_d;
        end
    end

    assign cursor_vis = cursor_vis_q;
`else
    logic unused_blink_div;
    assign unused_blink_div = |BLINK_DIV;
    assign cursor_vis       = 1'b1;
`endif

endmodule

// File: tb/tb_char_text_buffer.sv
// Directed self-checking bench for char_text_buffer: reset sweep, printing, newline, scroll, clear, blink.
module tb_char_text_buffer;
    import char_tbl_pkg::*;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] in_code = 6'd0;
    logic [5:0] rd_col = 6'd0;
    logic [3:0] rd_row = 4'd0;
    logic [5:0] rd_code;
    logic [5:0] cur_col;
    logic [3:0] cur_row;
    logic       busy;
    logic       cursor_vis;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    char_text_buffer #(.COLS(40), .ROWS(15), .BLINK_DIV(4)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .rd_col     (rd_col),
        .rd_row     (rd_row),
        .rd_code    (rd_code),
        .cur_col    (cur_col),
        .cur_row    (cur_row),
        .busy       (busy),
        .cursor_vis (cursor_vis)
    );

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // All tasks start and end on a negedge; inputs change there, outputs are sampled there.
    task automatic send(input logic [5:0] code);
        int w = 0;
        while (!in_ready && w < 2000) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL send_wait: in_ready=%0b required 1 for code %0d", in_ready, code);
        end
        in_valid = 1'b1;
        in_code  = code;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic read_cell(input int r, input int c, output logic [5:0] code);
        rd_row = 4'(r);
        rd_col = 6'(c);
        @(posedge clk);
        @(negedge clk);
        code = rd_code;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 2000) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
    endtask

    task automatic scan_spaces(output int n_space, output int bad_r, output int bad_c);
        logic [5:0] v;
        n_space = 0;
        bad_r = -1;
        bad_c = -1;
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < 40; c++) begin
                read_cell(r, c, v);
                if (v == CH_SPACE) n_space++;
                else if (bad_r < 0) begin
                    bad_r = r;
                    bad_c = c;
                end
            end
        end
    endtask

    function automatic logic [5:0] exp_after_scroll(input int r, input int c);
        if (r == 1) return (c < 5) ? 6'(26 + c) : CH_SPACE;
        if (r == 2) return 6'(c % 37);
        if (r == 13) return (c < 39) ? 6'((c + 10) % 37) : CH_H;
        return CH_SPACE;
    endfunction

    task automatic test_reset;
        int n, ns, br, bc;
        clr_n = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_in_ready: got %0b expected 0", in_ready); end
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL reset_busy: got %0b expected 1", busy); end
        checks++; if (cur_col !== 6'd0) begin fails++; $display("[TB] FAIL reset_cur_col: got %0d expected 0", cur_col); end
        checks++; if (cur_row !== 4'd0) begin fails++; $display("[TB] FAIL reset_cur_row: got %0d expected 0", cur_row); end
        checks++; if (rd_code !== CH_SPACE) begin fails++; $display("[TB] FAIL reset_rd_code: got %0d expected 36", rd_code); end
        checks++; if (cursor_vis !== 1'b1) begin fails++; $display("[TB] FAIL reset_cursor_vis: got %0b expected 1", cursor_vis); end
        clr_n = 1'b1;
        in_valid = 1'b1;
        in_code = 6'd45;
        count_busy(n);
        in_valid = 1'b0;
        checks++; if (n !== 600) begin fails++; $display("[TB] FAIL reset_clear_len: got %0d cycles expected 600", n); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready_after: got %0b expected 1", in_ready); end
        scan_spaces(ns, br, bc);
        checks++; if (ns !== 600) begin fails++; $display("[TB] FAIL reset_cells: %0d blank cells expected 600, first bad (%0d,%0d)", ns, br, bc); end
    endtask

    task automatic test_print;
        logic [5:0] v;
        send(CH_A);
        rd_row = 4'd0;
        rd_col = 6'd1;
        send(CH_B);
        checks++; if (rd_code !== CH_SPACE) begin fails++; $display("[TB] FAIL print_rbw_old: got %0d expected 36", rd_code); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (rd_code !== CH_B) begin fails++; $display("[TB] FAIL print_read_new: got %0d expected 1", rd_code); end
        send(CH_C);
        for (int c = 0; c < 4; c++) begin
            read_cell(0, c, v);
            checks++;
            if (v !== ((c < 3) ? 6'(c) : CH_SPACE)) begin
                fails++;
                $display("[TB] FAIL print_cell_0_%0d: got %0d expected %0d", c, v, (c < 3) ? c : 36);
            end
        end
        checks++; if (cur_col !== 6'd3 || cur_row !== 4'd0) begin fails++; $display("[TB] FAIL print_cursor: got (%0d,%0d) expected (0,3)", cur_row, cur_col); end
        read_cell(0, 40, v);
        checks++; if (v !== CH_SPACE) begin fails++; $display("[TB] FAIL oor_col: got %0d expected 36", v); end
        read_cell(15, 0, v);
        checks++; if (v !== CH_SPACE) begin fails++; $display("[TB] FAIL oor_row: got %0d expected 36", v); end
        read_cell(0, 0, v);
        checks++; if (v !== CH_A) begin fails++; $display("[TB] FAIL print_reread_0_0: got %0d expected 0", v); end
    endtask

    task automatic test_newline;
        logic [5:0] v;
        send(CH_NEWLINE);
        send(CH_NEWLINE);
        for (int c = 0; c < 5; c++) send(6'(26 + c));
        checks++; if (cur_col !== 6'd5 || cur_row !== 4'd2) begin fails++; $display("[TB] FAIL nl_pre_cursor: got (%0d,%0d) expected (2,5)", cur_row, cur_col); end
        send(CH_NEWLINE);
        checks++; if (cur_col !== 6'd0 || cur_row !== 4'd3) begin fails++; $display("[TB] FAIL nl_cursor: got (%0d,%0d) expected (3,0)", cur_row, cur_col); end
        read_cell(2, 5, v);
        checks++; if (v !== CH_SPACE) begin fails++; $display("[TB] FAIL nl_no_write: got %0d expected 36", v); end
        read_cell(2, 4, v);
        checks++; if (v !== CH_5) begin fails++; $display("[TB] FAIL nl_cell_2_4: got %0d expected 30", v); end
        send(6'd45);
        checks++; if (cur_col !== 6'd0 || cur_row !== 4'd3) begin fails++; $display("[TB] FAIL discard_cursor: got (%0d,%0d) expected (3,0)", cur_row, cur_col); end
        read_cell(3, 0, v);
        checks++; if (v !== CH_SPACE) begin fails++; $display("[TB] FAIL discard_no_write: got %0d expected 36", v); end
    endtask

    task automatic test_scroll;
        int n, ready_bad, bad, br, bc;
        logic [5:0] v, bv, ev;
        for (int c = 0; c < 40; c++) send(6'(c % 37));
        checks++; if (cur_col !== 6'd0 || cur_row !== 4'd4) begin fails++; $display("[TB] FAIL fill_wrap: got (%0d,%0d) expected (4,0)", cur_row, cur_col); end
        repeat (10) send(CH_NEWLINE);
        for (int c = 0; c < 39; c++) send(6'((c + 10) % 37));
        checks++; if (cur_col !== 6'd39 || cur_row !== 4'd14) begin fails++; $display("[TB] FAIL fill_last: got (%0d,%0d) expected (14,39)", cur_row, cur_col); end
        send(CH_H);
        in_valid = 1'b1;
        in_code = 6'd45;
        n = 0;
        ready_bad = 0;
        while (busy && n < 2000) begin
            if (in_ready) ready_bad++;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        checks++; if (n !== 601) begin fails++; $display("[TB] FAIL scroll_len: got %0d cycles expected 601", n); end
        checks++; if (ready_bad !== 0) begin fails++; $display("[TB] FAIL scroll_ready: in_ready high %0d cycles expected 0", ready_bad); end
        checks++; if (cur_col !== 6'd0 || cur_row !== 4'd14) begin fails++; $display("[TB] FAIL scroll_cursor: got (%0d,%0d) expected (14,0)", cur_row, cur_col); end
        for (int r = 0; r < 15; r++) begin
            bad = 0;
            bc = -1;
            bv = 6'd0;
            ev = 6'd0;
            for (int c = 0; c < 40; c++) begin
                read_cell(r, c, v);
                if (v !== exp_after_scroll(r, c)) begin
                    if (bad == 0) begin
                        bc = c;
                        bv = v;
                        ev = exp_after_scroll(r, c);
                    end
                    bad++;
                end
            end
            br = r;
            checks++;
            if (bad !== 0) begin
                fails++;
                $display("[TB] FAIL scroll_row_%0d: %0d bad cells, col %0d got %0d expected %0d", br, bad, bc, bv, ev);
            end
        end
    endtask

    task automatic test_reset_mid_scroll;
        int n, ns, br, bc;
        for (int c = 0; c < 40; c++) send(CH_B);
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL midscroll_enter: busy=%0b expected 1", busy); end
        repeat (100) @(negedge clk);
        clr_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin fails++; $display("[TB] FAIL midreset_flags: ready=%0b busy=%0b expected 0/1", in_ready, busy); end
        checks++; if (cur_col !== 6'd0 || cur_row !== 4'd0) begin fails++; $display("[TB] FAIL midreset_cursor: got (%0d,%0d) expected (0,0)", cur_row, cur_col); end
        checks++; if (rd_code !== CH_SPACE || cursor_vis !== 1'b1) begin fails++; $display("[TB] FAIL midreset_out: rd_code=%0d vis=%0b expected 36/1", rd_code, cursor_vis); end
        @(negedge clk);
        clr_n = 1'b1;
        count_busy(n);
        checks++; if (n !== 600) begin fails++; $display("[TB] FAIL midreset_clear_len: got %0d expected 600", n); end
        scan_spaces(ns, br, bc);
        checks++; if (ns !== 600) begin fails++; $display("[TB] FAIL midreset_cells: %0d blank expected 600, first bad (%0d,%0d)", ns, br, bc); end
    endtask

    task automatic test_clear_cmd;
        int n;
        logic [5:0] v;
        send(CH_D);
        send(CH_D);
        checks++; if (cur_col !== 6'd2) begin fails++; $display("[TB] FAIL clrcmd_pre: col got %0d expected 2", cur_col); end
        send(CH_CLEAR);
        checks++; if (cur_col !== 6'd0 || cur_row !== 4'd0 || busy !== 1'b1) begin fails++; $display("[TB] FAIL clrcmd_enter: (%0d,%0d) busy=%0b expected (0,0) 1", cur_row, cur_col, busy); end
        count_busy(n);
        checks++; if (n !== 600) begin fails++; $display("[TB] FAIL clrcmd_len: got %0d expected 600", n); end
        read_cell(0, 1, v);
        checks++; if (v !== CH_SPACE) begin fails++; $display("[TB] FAIL clrcmd_cell: got %0d expected 36", v); end
    endtask

    task automatic test_blink;
        int bad;
        logic ev;
        send(6'd45);
        bad = 0;
        for (int k = 0; k < 12; k++) begin
`ifdef CHAR_TEXT_BUFFER_CURSOR_BLINK_EN
            ev = ((k / 4) % 2) == 0;
`else
            ev = 1'b1;
`endif
            if (cursor_vis !== ev) bad++;
            @(posedge clk);
            @(negedge clk);
        end
        checks++; if (bad !== 0) begin fails++; $display("[TB] FAIL blink_pattern: %0d bad samples expected 0", bad); end
`ifdef CHAR_TEXT_BUFFER_CURSOR_BLINK_EN
        ev = 1'b0;
`else
        ev = 1'b1;
`endif
        checks++; if (cursor_vis !== ev) begin fails++; $display("[TB] FAIL blink_off_phase: got %0b expected %0b", cursor_vis, ev); end
        send(6'd45);
        checks++; if (cursor_vis !== 1'b1) begin fails++; $display("[TB] FAIL blink_restart: got %0b expected 1", cursor_vis); end
    endtask

    initial begin
        test_reset();
        test_print();
        test_newline();
        test_scroll();
        test_reset_mid_scroll();
        test_clear_cmd();
        test_blink();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
